// File: rtl/axi4l_rd_slave.sv
// AXI4-Lite read-channel slave: accepts one AR at a time, strobes the register-file read
// port, waits for its acknowledge (bounded by TIMEOUT) and returns the beat on R.
module axi4l_rd_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int REG_COUNT      = 16,
  parameter int TIMEOUT        = 16
) (
  input  logic                      axi4l_clock,
  input  logic                      axi_areset,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  input  logic [2:0]                axi_arprot,
  input  logic                      axi_araddr_valid,
  output logic                      axi_araddr_ready,
  output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]                axi_rresp,
  output logic                      axi_rdata_valid,
  input  logic                      axi_rdata_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi4l_raddr,
  output logic                      axi4l_rreq,
  input  logic [AXI_DATA_WIDTH-1:0] axi4l_rdata,
  input  logic                      axi4l_rack
);

  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH / 8);
  localparam int CNT_W    = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]          TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [AXI_ADDR_WIDTH-1:0] REG_COUNT_C = AXI_ADDR_WIDTH'(REG_COUNT);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                    state_q,  state_d;
  logic                      arready_q, arready_d;
  logic                      rreq_q,   rreq_d;
  logic [AXI_ADDR_WIDTH-1:0] raddr_q,  raddr_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic [1:0]                rresp_q,  rresp_d;
  logic                      rvalid_q, rvalid_d;
  logic [CNT_W-1:0]          cnt_q,    cnt_d;
  logic [2:0]                prot_q,   prot_d;
  logic [CNT_W-1:0]          cnt_inc;

  // Low address bits below the word boundary do not take part in decoding.
  function automatic logic addr_in_map(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return (addr >> ADDR_LSB) < REG_COUNT_C;
  endfunction

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    arready_d = 1'b0;
    rreq_d    = 1'b0;
    raddr_d   = '0;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rvalid_d  = rvalid_q;
    cnt_d     = cnt_q;
    prot_d    = prot_q;

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (axi_araddr_valid && arready_q) begin
          arready_d = 1'b0;
          prot_d    = axi_arprot;
          if (addr_in_map(axi_araddr)) begin
            state_d = WAIT;
            rreq_d  = 1'b1;
            raddr_d = axi_araddr;
            cnt_d   = '0;
          end else begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_DECERR;
            rdata_d  = '0;
          end
        end
      end

      WAIT: begin
        // The acknowledge wins even on the last permitted cycle.
        if (axi4l_rack) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rresp_d  = RESP_OKAY;
          rdata_d  = axi4l_rdata;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rresp_d  = RESP_SLVERR;
          rdata_d  = '0;
          cnt_d    = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      RESP: begin
        if (axi_rdata_ready) begin
          state_d   = IDLE;
          rvalid_d  = 1'b0;
          rresp_d   = RESP_OKAY;
          rdata_d   = '0;
          arready_d = 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        rvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axi4l_clock) begin
    if (axi_areset) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rreq_q    <= 1'b0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rreq_q    <= rreq_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
      cnt_q     <= cnt_d;
      prot_q    <= prot_d;
    end
  end

  // Protection attributes are kept for observability only.
  logic unused_prot;
  assign unused_prot = ^prot_q;

  assign axi_araddr_ready = arready_q;
  assign axi_rdata        = rdata_q;
  assign axi_rresp        = rresp_q;
  assign axi_rdata_valid  = rvalid_q;
  assign axi4l_raddr      = raddr_q;
  assign axi4l_rreq       = rreq_q;

endmodule

// File: tb/tb_axi4l_rd_slave.sv
// Bench for axi4l_rd_slave: table of read transactions checked through an R-beat
// scoreboard, plus hand-written reset sequences.
module tb_axi4l_rd_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] rf_addr;
  logic        rf_req;
  logic [31:0] rf_data = '0;
  logic        rf_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    int          rack_dly;   // rack asserted in cycle 1+rack_dly after AR, -1 = never
    logic [31:0] data;
    int          rrdy;       // rready high from this cycle after AR onwards
    bit          hold;       // keep araddr_valid high until the R handshake
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    int          exp_lat;    // first cycle after AR with rdata_valid=1
    bit          exp_rreq;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } beat_t;

  vec_t  tbl[8];
  beat_t sb[$];

  axi4l_rd_slave #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .REG_COUNT(16),
    .TIMEOUT(16)
  ) dut (
    .axi4l_clock(clk),
    .axi_areset(rst),
    .axi_araddr(araddr),
    .axi_arprot(arprot),
    .axi_araddr_valid(arvalid),
    .axi_araddr_ready(arready),
    .axi_rdata(rdata),
    .axi_rresp(rresp),
    .axi_rdata_valid(rvalid),
    .axi_rdata_ready(rready),
    .axi4l_raddr(rf_addr),
    .axi4l_rreq(rf_req),
    .axi4l_rdata(rf_data),
    .axi4l_rack(rf_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    h;
    bit    done;
    beat_t b;
    string tag;
    tag = $sformatf("v%0d", idx);
    h = (v.exp_lat > v.rrdy) ? v.exp_lat : v.rrdy;
    chk({tag, "_arready_idle"}, arready, 1);
    araddr  = v.addr;
    arprot  = 3'($urandom);
    arvalid = 1'b1;
    sb.push_back('{data: v.exp_data, resp: v.exp_resp});
    done = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      step();
      arvalid = v.hold && (k < h);
      rf_ack  = (v.rack_dly >= 0) && (k == 1 + v.rack_dly);
      rf_data = rf_ack ? v.data : $urandom;
      rready  = (k >= v.rrdy);
      if (k == 1) begin
        chk({tag, "_rreq"}, rf_req, v.exp_rreq);
        if (v.exp_rreq) chk({tag, "_raddr"}, rf_addr, v.addr);
      end else begin
        chk({tag, "_rreq_once"}, rf_req, 0);
      end
      chk({tag, "_arready_busy"}, arready, 0);
      chk({tag, "_rvalid"}, rvalid, (k >= v.exp_lat));
      if (rvalid) begin
        if (sb.size() == 0) begin
          chk({tag, "_unexpected_beat"}, 1, 0);
        end else begin
          chk({tag, "_rdata"}, rdata, sb[0].data);
          chk({tag, "_rresp"}, rresp, sb[0].resp);
          if (rready) begin
            b = sb.pop_front();
            done = 1'b1;
          end
        end
      end
    end
    if (!done) begin
      chk({tag, "_beat_timeout"}, sb.size(), 0);
      sb.delete();
    end
    step();
    rf_ack  = 1'b0;
    rready  = 1'b0;
    arvalid = 1'b0;
    chk({tag, "_no_second_beat"}, rvalid, 0);
  endtask

  initial begin
    tbl[0] = '{32'h0000_0008,  0, 32'hDEAD_BEEF,  1, 1'b0, 2'b00, 32'hDEAD_BEEF,  2, 1'b1};
    tbl[1] = '{32'h0000_0040, -1, 32'h0,          1, 1'b0, 2'b11, 32'h0,          1, 1'b0};
    tbl[2] = '{32'h0000_0004, 20, 32'h1111_2222, 25, 1'b0, 2'b10, 32'h0,         17, 1'b1};
    tbl[3] = '{32'h0000_000C,  5, 32'hCAFE_F00D, 11, 1'b1, 2'b00, 32'hCAFE_F00D,  7, 1'b1};
    tbl[4] = '{32'h0000_003F,  1, 32'h1234_5678,  3, 1'b0, 2'b00, 32'h1234_5678,  3, 1'b1};
    tbl[5] = '{32'hFFFF_FFF0, -1, 32'h0,          3, 1'b1, 2'b11, 32'h0,          1, 1'b0};
    tbl[6] = '{32'h0000_0000, 15, 32'hA5A5_A5A5,  1, 1'b0, 2'b00, 32'hA5A5_A5A5, 17, 1'b1};
    tbl[7] = '{32'h0000_0010, 16, 32'h5A5A_5A5A, 17, 1'b0, 2'b10, 32'h0,         17, 1'b1};

    // power-on reset, three cycles
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rreq", rf_req, 0);
    chk("rst_rresp", rresp, 0);
    rst = 1'b0;
    step();
    chk("rel_arready", arready, 1);
    chk("rel_rvalid", rvalid, 0);
    chk("rel_rreq", rf_req, 0);
    chk("rel_rresp", rresp, 0);
    chk("rel_rdata", rdata, 0);

    // spurious acknowledge while idle
    rf_ack  = 1'b1;
    rf_data = 32'hBAD0_BAD0;
    step();
    rf_ack = 1'b0;
    chk("idle_ack_rvalid", rvalid, 0);
    chk("idle_ack_arready", arready, 1);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // reset while waiting for the acknowledge
    chk("mid_arready", arready, 1);
    araddr  = 32'h0000_0014;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("mid_rreq", rf_req, 1);
    step();
    rst     = 1'b1;
    rf_ack  = 1'b1;
    rf_data = 32'h7777_7777;
    step();
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_arready", arready, 0);
    chk("mid_rst_rreq", rf_req, 0);
    step();
    rst    = 1'b0;
    rf_ack = 1'b0;
    rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_post_rvalid", rvalid, 0);
      chk("mid_post_arready", arready, 1);
    end
    rf_ack = 1'b1;
    step();
    rf_ack = 1'b0;
    rready = 1'b0;
    chk("mid_late_ack_rvalid", rvalid, 0);

    run_vec(tbl[0], 8);
    run_vec(tbl[4], 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
